// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: register map, character codes,
// cursor controller FSM states and default screen geometry.
package text_console_pkg;

   localparam int DEF_COLS = 80;
   localparam int DEF_ROWS = 30;

   // CPU register select values
   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_COL  = 2'd1;
   localparam logic [1:0] REG_ROW  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   // Character codes with special meaning on a DATA write
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_DEL   = 8'h7F;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLR_LINE = 2'd1,
      ST_CLR_ALL  = 2'd2
   } cursor_state_t;

   // Codes that put a glyph into VRAM: 0x20-0x7E and the whole upper half.
   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_SPACE) && (c != CH_DEL);
   endfunction

endpackage

// File: rtl/text_addr_map.sv
// Logical (row, col) to physical VRAM address. The screen scrolls by moving
// top_row, so the physical row is the logical row rotated by top_row.
module text_addr_map
   import text_console_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int COL_W  = 7,
   parameter int ROW_W  = 5,
   parameter int ADDR_W = 12
) (
   input  logic [ROW_W-1:0]  row,
   input  logic [COL_W-1:0]  col,
   input  logic [ROW_W-1:0]  top_row,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [ROW_W:0] ROWS_EXT = (ROW_W+1)'(ROWS);

   logic [ROW_W:0]   row_sum;
   logic [ROW_W-1:0] phys_row;

   // Both operands are below ROWS, so one conditional subtract is a full mod.
   assign row_sum  = {1'b0, row} + {1'b0, top_row};
   assign phys_row = (row_sum >= ROWS_EXT) ? ROW_W'(row_sum - ROWS_EXT) : ROW_W'(row_sum);
   assign addr     = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col);

endmodule

// File: rtl/text_cursor_ctrl.sv
// Terminal-style cursor controller: decodes CPU register writes, writes
// characters into text VRAM, moves the cursor, scrolls via top_row and runs
// the line / full-screen clear engines.
module text_cursor_ctrl
   import text_console_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int COL_W  = 7,
   parameter int ROW_W  = 5,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [1:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic              busy,
   output logic              dropped,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   output logic [COL_W-1:0]  cursor_col,
   output logic [ROW_W-1:0]  cursor_row,
   output logic [ROW_W-1:0]  top_row,
   output logic              cursor_moved
);

   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [7:0]        MAX_COL8   = 8'(COLS - 1);
   localparam logic [7:0]        MAX_ROW8   = 8'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LINE_LEN   = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] SCREEN_LEN = ADDR_W'(COLS * ROWS);

   cursor_state_t     state;
   logic [ADDR_W-1:0] clr_cnt;      // next index to clear within the line/screen
   logic [ADDR_W-1:0] line_base_q;  // physical base address of the line being cleared
   logic [ADDR_W-1:0] cur_addr;     // physical address under the cursor
   logic [ADDR_W-1:0] line_base;    // physical base of the current top row
   logic              scroll;
   logic [ROW_W-1:0]  nl_row;
   logic [ROW_W-1:0]  nl_top;
   logic [COL_W-1:0]  col_clamp;
   logic [ROW_W-1:0]  row_clamp;

   text_addr_map #(
      .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
   ) u_cursor_map (
      .row     (cursor_row),
      .col     (cursor_col),
      .top_row (top_row),
      .addr    (cur_addr)
   );

   // After a scroll the old top row becomes the new bottom row, so its base
   // address is where the line clear starts.
   text_addr_map #(
      .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
   ) u_line_map (
      .row     ('0),
      .col     ('0),
      .top_row (top_row),
      .addr    (line_base)
   );

   // Newline outcome: step down, or at the bottom keep the row and scroll.
   assign scroll    = (cursor_row == LAST_ROW);
   assign nl_row    = scroll ? cursor_row : cursor_row + ROW_W'(1);
   assign nl_top    = (top_row == LAST_ROW) ? '0 : top_row + ROW_W'(1);
   assign col_clamp = (wr_data > MAX_COL8) ? LAST_COL : COL_W'(wr_data);
   assign row_clamp = (wr_data > MAX_ROW8) ? LAST_ROW : ROW_W'(wr_data);

   // Register-write decode, cursor movement and the two clear engines.
   // Clear engines issue their first write in the cycle they are entered
   // (except after a wrapping char, whose own write occupies that cycle) and
   // stay busy until the cycle carrying the last space write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         dropped      <= 1'b0;
         vram_we      <= 1'b0;
         vram_addr    <= '0;
         vram_wdata   <= '0;
         cursor_col   <= '0;
         cursor_row   <= '0;
         top_row      <= '0;
         cursor_moved <= 1'b0;
         clr_cnt      <= '0;
         line_base_q  <= '0;
      end else begin
         vram_we      <= 1'b0;
         cursor_moved <= 1'b0;
         if (wr_en && (state != ST_IDLE)) dropped <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (wr_en) begin
                  case (wr_addr)
                     REG_DATA: begin
                        if (is_printable(wr_data)) begin
                           vram_we      <= 1'b1;
                           vram_addr    <= cur_addr;
                           vram_wdata   <= wr_data;
                           cursor_moved <= 1'b1;
                           if (cursor_col == LAST_COL) begin
                              cursor_col <= '0;
                              cursor_row <= nl_row;
                              if (scroll) begin
                                 top_row     <= nl_top;
                                 line_base_q <= line_base;
                                 clr_cnt     <= '0;
                                 state       <= ST_CLR_LINE;
                                 busy        <= 1'b1;
                              end
                           end else begin
                              cursor_col <= cursor_col + COL_W'(1);
                           end
                        end else if (wr_data == CH_CR) begin
                           cursor_col   <= '0;
                           cursor_moved <= 1'b1;
                        end else if (wr_data == CH_LF) begin
                           cursor_row   <= nl_row;
                           cursor_moved <= 1'b1;
                           if (scroll) begin
                              top_row     <= nl_top;
                              line_base_q <= line_base;
                              vram_we     <= 1'b1;
                              vram_addr   <= line_base;
                              vram_wdata  <= CH_SPACE;
                              clr_cnt     <= ADDR_W'(1);
                              state       <= ST_CLR_LINE;
                              busy        <= 1'b1;
                           end
                        end else if (wr_data == CH_BS) begin
                           if (cursor_col != '0) begin
                              cursor_col   <= cursor_col - COL_W'(1);
                              vram_we      <= 1'b1;
                              vram_addr    <= cur_addr - ADDR_W'(1);
                              vram_wdata   <= CH_SPACE;
                              cursor_moved <= 1'b1;
                           end
                        end else if (wr_data == CH_FF) begin
                           top_row      <= '0;
                           cursor_col   <= '0;
                           cursor_row   <= '0;
                           cursor_moved <= 1'b1;
                           vram_we      <= 1'b1;
                           vram_addr    <= '0;
                           vram_wdata   <= CH_SPACE;
                           clr_cnt      <= ADDR_W'(1);
                           state        <= ST_CLR_ALL;
                           busy         <= 1'b1;
                        end
                     end
                     REG_COL: begin
                        cursor_col   <= col_clamp;
                        cursor_moved <= 1'b1;
                     end
                     REG_ROW: begin
                        cursor_row   <= row_clamp;
                        cursor_moved <= 1'b1;
                     end
                     default: begin
                        if (wr_data[7]) dropped <= 1'b0;
                        if (wr_data[0]) begin
                           top_row      <= '0;
                           cursor_col   <= '0;
                           cursor_row   <= '0;
                           cursor_moved <= 1'b1;
                           vram_we      <= 1'b1;
                           vram_addr    <= '0;
                           vram_wdata   <= CH_SPACE;
                           clr_cnt      <= ADDR_W'(1);
                           state        <= ST_CLR_ALL;
                           busy         <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            ST_CLR_LINE: begin
               if (clr_cnt == LINE_LEN) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  vram_we    <= 1'b1;
                  vram_addr  <= line_base_q + clr_cnt;
                  vram_wdata <= CH_SPACE;
                  clr_cnt    <= clr_cnt + ADDR_W'(1);
               end
            end
            ST_CLR_ALL: begin
               if (clr_cnt == SCREEN_LEN) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  vram_we    <= 1'b1;
                  vram_addr  <= clr_cnt;
                  vram_wdata <= CH_SPACE;
                  clr_cnt    <= clr_cnt + ADDR_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Self-checking bench for text_cursor_ctrl: directed scenarios plus random
// register writes, all checked against a screen-level reference model.
module tb_text_cursor_ctrl;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        busy, dropped, vram_we, cursor_moved;
   logic [11:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row, top_row;

   text_cursor_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .dropped      (dropped),
      .vram_we      (vram_we),
      .vram_addr    (vram_addr),
      .vram_wdata   (vram_wdata),
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row),
      .top_row      (top_row),
      .cursor_moved (cursor_moved)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int m_col, m_row, m_top;
   bit m_dropped;

   function automatic int m_addr(input int r, input int c);
      return ((r + m_top) % ROWS) * COLS + c;
   endfunction

   // ---------------- scoreboard ----------------
   logic [19:0] exp_q[$];   // {addr, data} of every expected VRAM write, in order
   logic [19:0] mon_exp;

   task automatic push(input int addr, input logic [7:0] d);
      exp_q.push_back({12'(addr), d});
   endtask

   task automatic model_newline(output bit scrolled);
      scrolled = 0;
      if (m_row < ROWS - 1) m_row++;
      else begin
         for (int c = 0; c < COLS; c++) push(m_top * COLS + c, 8'h20);
         m_top = (m_top + 1) % ROWS;
         scrolled = 1;
      end
   endtask

   task automatic model_clear_all();
      m_top = 0; m_row = 0; m_col = 0;
      for (int i = 0; i < ROWS * COLS; i++) push(i, 8'h20);
   endtask

   task automatic model_reset();
      m_col = 0; m_row = 0; m_top = 0; m_dropped = 0;
   endtask

   // Apply one accepted write to the model; returns whether the cursor pulse
   // is expected and how many cycles busy must stay high.
   task automatic model_apply(input logic [1:0] a, input logic [7:0] d,
                              output bit pulse, output int busy_len);
      bit sc;
      pulse = 0; busy_len = 0;
      case (a)
         2'd0: begin
            if (d >= 8'h20 && d != 8'h7F) begin
               push(m_addr(m_row, m_col), d);
               pulse = 1;
               if (m_col == COLS - 1) begin
                  m_col = 0;
                  model_newline(sc);
                  if (sc) busy_len = COLS + 1;
               end else m_col++;
            end else if (d == 8'h0D) begin
               m_col = 0; pulse = 1;
            end else if (d == 8'h0A) begin
               pulse = 1;
               model_newline(sc);
               if (sc) busy_len = COLS;
            end else if (d == 8'h08) begin
               if (m_col > 0) begin
                  m_col--;
                  push(m_addr(m_row, m_col), 8'h20);
                  pulse = 1;
               end
            end else if (d == 8'h0C) begin
               model_clear_all(); pulse = 1; busy_len = ROWS * COLS;
            end
         end
         2'd1: begin m_col = (d > COLS - 1) ? COLS - 1 : int'(d); pulse = 1; end
         2'd2: begin m_row = (d > ROWS - 1) ? ROWS - 1 : int'(d); pulse = 1; end
         default: begin
            if (d[7]) m_dropped = 0;
            if (d[0]) begin model_clear_all(); pulse = 1; busy_len = ROWS * COLS; end
         end
      endcase
   endtask

   // Monitor: every VRAM write must be the next expected one.
   always @(negedge clk) begin
      if (reset === 1'b0 && vram_we === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL vram_write: got addr %0d data %h, required no write", vram_addr, vram_wdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({vram_addr, vram_wdata} !== mon_exp) begin
               n_fail++;
               $display("FAIL vram_write: got addr %0d data %h, required addr %0d data %h",
                        vram_addr, vram_wdata, mon_exp[19:8], mon_exp[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called and returns at 1 time unit after a rising edge.
   task automatic drive(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
   endtask

   // One accepted write with full checking of the cycle after the edge,
   // the busy length and the drained scoreboard.
   task automatic send(input logic [1:0] a, input logic [7:0] d, input string tag);
      bit pulse;
      int blen, q0, guard;
      bit exp_we;
      q0 = exp_q.size();
      model_apply(a, d, pulse, blen);
      exp_we = (exp_q.size() > q0);
      drive(a, d);
      n_tests++;
      if (cursor_col !== 7'(m_col)) begin n_fail++; $display("FAIL %s col: got %0d, required %0d", tag, cursor_col, m_col); end
      n_tests++;
      if (cursor_row !== 5'(m_row)) begin n_fail++; $display("FAIL %s row: got %0d, required %0d", tag, cursor_row, m_row); end
      n_tests++;
      if (top_row !== 5'(m_top)) begin n_fail++; $display("FAIL %s top_row: got %0d, required %0d", tag, top_row, m_top); end
      n_tests++;
      if (cursor_moved !== pulse) begin n_fail++; $display("FAIL %s cursor_moved: got %b, required %b", tag, cursor_moved, pulse); end
      n_tests++;
      if (vram_we !== exp_we) begin n_fail++; $display("FAIL %s vram_we: got %b, required %b", tag, vram_we, exp_we); end
      if (exp_we) begin
         n_tests++;
         if ({vram_addr, vram_wdata} !== exp_q[q0]) begin
            n_fail++;
            $display("FAIL %s first_write: got addr %0d data %h, required addr %0d data %h",
                     tag, vram_addr, vram_wdata, exp_q[q0][19:8], exp_q[q0][7:0]);
         end
      end
      n_tests++;
      if (dropped !== m_dropped) begin n_fail++; $display("FAIL %s dropped: got %b, required %b", tag, dropped, m_dropped); end
      guard = 0;
      while (busy === 1'b1 && guard < 3000) begin
         guard++; @(posedge clk); #1;
      end
      n_tests++;
      if (guard != blen) begin n_fail++; $display("FAIL %s busy_cycles: got %0d, required %0d", tag, guard, blen); end
      @(posedge clk); #1;
      n_tests++;
      if (cursor_moved !== 1'b0) begin n_fail++; $display("FAIL %s pulse_width: cursor_moved still %b, required 0", tag, cursor_moved); end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s writes_missing: got %0d outstanding, required 0", tag, exp_q.size()); end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      n_tests++;
      if ({busy, dropped, vram_we, vram_addr, vram_wdata, cursor_col, cursor_row, top_row, cursor_moved} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b dropped=%b we=%b addr=%0d data=%h col=%0d row=%0d top=%0d moved=%b, required all 0",
                  busy, dropped, vram_we, vram_addr, vram_wdata, cursor_col, cursor_row, top_row, cursor_moved);
      end
   endtask

   task automatic test_char_write();
      send(2'd0, 8'h41, "char_A");          // addr 0, col -> 1
      n_tests++;
      if (cursor_col !== 7'd1) begin n_fail++; $display("FAIL char_A_col_const: got %0d, required 1", cursor_col); end
      send(2'd0, 8'hE5, "char_high");
      send(2'd0, 8'h0D, "cr");
   endtask

   task automatic test_wrap_scroll();
      send(2'd1, 8'd79, "col79");
      send(2'd2, 8'd29, "row29");
      send(2'd0, 8'h42, "wrap_scroll");     // addr 2399, then line 0 cleared, 81 busy cycles
      n_tests++;
      if ({top_row, cursor_row, cursor_col} !== {5'd1, 5'd29, 7'd0}) begin
         n_fail++; $display("FAIL wrap_scroll_pos: got top=%0d row=%0d col=%0d, required 1 29 0", top_row, cursor_row, cursor_col);
      end
      send(2'd0, 8'h43, "after_scroll");    // physical row 0 is logical row 29
      send(2'd0, 8'h0A, "lf_bottom");       // 80 busy cycles
   endtask

   task automatic test_backspace();
      send(2'd1, 8'd5, "col5");
      send(2'd0, 8'h08, "bs_mid");
      send(2'd1, 8'd0, "col0");
      send(2'd0, 8'h08, "bs_col0");
   endtask

   task automatic test_back_to_back();
      bit pulse;
      int blen, guard;
      model_apply(2'd0, 8'h0C, pulse, blen);
      drive(2'd0, 8'h0C);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL ff_busy: got %b, required 1", busy); end
      drive(2'd0, 8'h41);                   // lands while busy: dropped, never written
      m_dropped = 1;
      n_tests++;
      if (dropped !== 1'b1) begin n_fail++; $display("FAIL ff_dropped: got %b, required 1", dropped); end
      guard = 1;
      while (busy === 1'b1 && guard < 3000) begin
         guard++; @(posedge clk); #1;
      end
      n_tests++;
      if (guard != blen) begin n_fail++; $display("FAIL ff_busy_cycles: got %0d, required %0d", guard, blen); end
      @(posedge clk); #1;
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL ff_writes_missing: got %0d outstanding, required 0", exp_q.size()); end
      send(2'd3, 8'h80, "ctrl_clear_dropped");
   endtask

   task automatic test_clamp_ignored();
      send(2'd1, 8'd200, "col_clamp");
      send(2'd2, 8'd255, "row_clamp");
      send(2'd0, 8'h07, "bell_ignored");
      send(2'd0, 8'h7F, "del_ignored");
      send(2'd3, 8'h7E, "ctrl_reserved");
   endtask

   task automatic test_random();
      int r;
      logic [1:0] a;
      logic [7:0] d;
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         a = 2'd0;
         if (r < 55)      d = 8'($urandom_range(32, 126));
         else if (r < 65) d = 8'h0A;
         else if (r < 70) d = 8'h0D;
         else if (r < 75) d = 8'h08;
         else if (r < 80) begin
            d = 8'($urandom_range(0, 31));
            if (d == 8'h0C) d = 8'h01;
         end
         else if (r < 83) d = 8'($urandom_range(128, 255));
         else if (r < 89) begin a = 2'd1; d = 8'($urandom_range(0, 255)); end
         else if (r < 95) begin a = 2'd2; d = 8'($urandom_range(0, 255)); end
         else if (r < 99) begin a = 2'd3; d = 8'($urandom_range(0, 255)) & 8'hFE; end
         else             begin a = 2'd3; d = 8'h01; end
         send(a, d, "random");
      end
   endtask

   task automatic test_reset_mid_clear();
      bit pulse;
      int blen;
      model_apply(2'd3, 8'h01, pulse, blen);
      drive(2'd3, 8'h01);
      repeat (100) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (vram_we !== 1'b0) begin n_fail++; $display("FAIL reset_mid_we: got %b, required 0", vram_we); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b, required 0", busy); end
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_resume: busy got %b, required 0", busy); end
      send(2'd0, 8'h41, "post_reset_char");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
      model_reset();
      test_reset();
      test_char_write();
      test_wrap_scroll();
      test_backspace();
      test_back_to_back();
      test_clamp_ignored();
      test_random();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
